ctrl_mc: RTL and testbench
==========================

Name: ctrl_mc

Overview:
Multi-cycle successor to the single-cycle control decoder of the 9-bit accumulator core. It decodes each instruction into the same control-flag set and adds a state machine for four things:
- variable-latency data-memory accesses, with a PC stall;
- a sticky halt;
- a parametrised branch-condition mode;
- parametrised accumulator width.

It sits between instruction memory and the datapath (PC, LUT, RegFile, Acc, DataMem).

Parameters:
INSTR_W, 9, instruction width; opcode is Instruction[INSTR_W-1 -: OP_W]
OP_W, 5, opcode field width
ACC_W, 8, accumulator width for branch test
MEM_LAT, 1, data-memory cycles per LDR/STR (1..15); 1 means single-cycle
BR_MODE, 0, BEQ condition: 0 = AccInput == 1; 1 = AccInput != 0
CNT_W, 16, width of performance counters (optional feature only)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Instruction  input  INSTR_W  machine code; held stable by PC while Stall=1
AccInput  input  ACC_W  accumulator value for BEQ
PC_Jmp_Flag, PC_Beq_Flag  output  1 each  PC control
LUT_Write_En, LUT_Read_En, LUT_Load_Hi  output  1 each  LUT control
Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc  output  1 each  RegFile control
Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm, Acc_Load_Hi  output  1 each  Acc control
Mem_Write_En  output  1  DataMem write
ALU_Opcode  output  5  ALU operation
Stall  output  1  PC hold request
Ack  output  1  done / halted

Behaviour:
- Clocking: one clock, Clk; Reset is synchronous and active-high.
- Registered state: FSM state {RUN, MEM_WAIT, HALT}; wait_cnt (4 bits).
- Output timing: all control outputs are combinational from state, wait_cnt, Instruction and AccInput, with zero latency in RUN.
- Reset: state=RUN, wait_cnt=0. With Reset high, every output is 0 in that cycle, including Ack and Stall.
- Decode in RUN:
  - AND/ORR/XOR_B/XOR_G/ADD/SHL/SHR: ALU_Opcode 00000/00001/00010/00011/00100/01100/01101; Reg_Write_En=1, Reg_From_ALU=1.
  - CMP/CMP_LS: ALU_Opcode 00111/01011; Acc_Write_En=1, Acc_From_ALU=1.
  - STA: Reg_Write_En=1, Reg_From_Acc=1.
  - LDA: Acc_Write_En=1, Acc_From_Reg=1.
  - SET_H/SET_L: Acc_Write_En=1, Acc_From_Imm=1, Acc_Load_Hi=1/0.
  - JMP: LUT_Read_En=1, PC_Jmp_Flag=1.
  - BEQ: LUT_Read_En=1; PC_Beq_Flag is set per BR_MODE, compared at full ACC_W width.
  - LD_LUT_H/LD_LUT_L: LUT_Write_En=1, LUT_Load_Hi=1/0.
  - Undefined opcode: all outputs 0; state stays RUN.
- LDR/STR with MEM_LAT=1: single cycle. LDR gives Reg_Write_En=1, Reg_From_Mem=1; STR gives Mem_Write_En=1; Stall=0.
- LDR/STR with MEM_LAT>1:
  - In RUN: Stall=1; load wait_cnt=MEM_LAT-1; go to MEM_WAIT.
  - In MEM_WAIT: decrement wait_cnt each cycle. Stall=1 while wait_cnt>1. When wait_cnt==1, Stall=0 and state returns to RUN.
  - STR: Mem_Write_En=1 in every access cycle.
  - LDR: Reg_From_Mem=1 in every access cycle; Reg_Write_En=1 only in the final cycle (Stall=0).
  - The opcode is re-decoded from the held Instruction in every access cycle.
- HLT, or an all-ones Instruction:
  - In RUN: Ack=1 and Stall=1 that cycle; next state HALT.
  - In HALT: Ack=1, Stall=1, all other outputs 0, regardless of Instruction. Only Reset leaves HALT.
- Reset mid-operation: Reset during MEM_WAIT aborts the access, with no write in that cycle. Next cycle is RUN with wait_cnt=0.
- Simultaneous events: Reset has priority over everything.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, add outputs Retire_Cnt and Stall_Cnt (CNT_W each, registered, reset 0, saturating at all-ones).
- Retire_Cnt increments once per completed instruction:
  - each RUN cycle with Stall=0;
  - the final MEM_WAIT cycle;
  - the HLT entry cycle.
- Stall_Cnt increments on every Stall=1 cycle outside HALT, excluding the HLT entry cycle.
- When undefined, both ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Definitions package:
  - opcode enum (existing);
  - ctrl_state_t enum {RUN, MEM_WAIT, HALT};
  - ctrl_word_t packed struct of all flags plus ALU_Opcode;
  - BR_EQ_ONE=0 and BR_NONZERO=1 constants;
  - ALU opcode localparams.
- Sub-module ctrl_decode: purely combinational; maps opcode, AccInput and BR_MODE to ctrl_word_t.
- ctrl_mc owns the FSM, wait_cnt, stall/final-cycle gating, HALT masking and the counters.

Test Plan:
1. Reset=1 for 2 cycles with Instruction=LDR -> all outputs 0; after release ADD gives Reg_Write_En=1, Reg_From_ALU=1, ALU_Opcode=00100, Stall=0 in the same cycle.
2. MEM_LAT=3, LDR held 3 cycles -> Stall 1,1,0; Reg_From_Mem 1,1,1; Reg_Write_En 0,0,1; then back in RUN.
3. MEM_LAT=3, STR, Reset asserted in cycle 2 -> Mem_Write_En=1 in cycle 1, 0 in cycle 2; cycle 3 RUN, Stall=0.
4. BEQ with BR_MODE=0: AccInput=8'h01 -> PC_Beq_Flag=1; 8'h02 -> 0. BR_MODE=1: 8'h02 -> 1; 8'h00 -> 0. LUT_Read_En=1 in all cases.
5. HLT then ADD, STR -> Ack=1 and Stall=1 every cycle with no enables; Reset -> Ack=0, RUN.
6. CTRL_PERF_CNT_EN, MEM_LAT=3: ADD, LDR, ADD -> Retire_Cnt=3, Stall_Cnt=2. Build without the macro also compiles and passes scenarios 1-5.

Source files
------------

// File: rtl/ctrl_mc_pkg.sv
// Shared definitions for the multi-cycle control decoder: opcodes, FSM states, control word.
// Combinational constants only; no timing or backpressure of its own.
package ctrl_mc_pkg;

    typedef enum logic [4:0] {
        OP_AND      = 5'd0,
        OP_ORR      = 5'd1,
        OP_XOR_B    = 5'd2,
        OP_XOR_G    = 5'd3,
        OP_ADD      = 5'd4,
        OP_STA      = 5'd5,
        OP_LDA      = 5'd6,
        OP_CMP      = 5'd7,
        OP_SET_H    = 5'd8,
        OP_SET_L    = 5'd9,
        OP_JMP      = 5'd10,
        OP_CMP_LS   = 5'd11,
        OP_SHL      = 5'd12,
        OP_SHR      = 5'd13,
        OP_BEQ      = 5'd14,
        OP_LD_LUT_H = 5'd15,
        OP_LD_LUT_L = 5'd16,
        OP_LDR      = 5'd17,
        OP_STR      = 5'd18,
        OP_HLT      = 5'd19
    } opcode_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic       pc_jmp_flag;
        logic       pc_beq_flag;
        logic       lut_write_en;
        logic       lut_read_en;
        logic       lut_load_hi;
        logic       reg_write_en;
        logic       reg_from_alu;
        logic       reg_from_mem;
        logic       reg_from_acc;
        logic       acc_write_en;
        logic       acc_from_reg;
        logic       acc_from_alu;
        logic       acc_from_imm;
        logic       acc_load_hi;
        logic       mem_write_en;
        logic [4:0] alu_opcode;
    } ctrl_word_t;

    localparam int BR_EQ_ONE  = 0;
    localparam int BR_NONZERO = 1;

    localparam logic [4:0] ALU_AND    = 5'b00000;
    localparam logic [4:0] ALU_ORR    = 5'b00001;
    localparam logic [4:0] ALU_XOR_B  = 5'b00010;
    localparam logic [4:0] ALU_XOR_G  = 5'b00011;
    localparam logic [4:0] ALU_ADD    = 5'b00100;
    localparam logic [4:0] ALU_CMP    = 5'b00111;
    localparam logic [4:0] ALU_CMP_LS = 5'b01011;
    localparam logic [4:0] ALU_SHL    = 5'b01100;
    localparam logic [4:0] ALU_SHR    = 5'b01101;

endpackage

// File: rtl/ctrl_mc_if.sv
// Instruction-in / control-flags-out bundle between instruction memory, decoder and datapath.
// Optional perf counters appear only when CTRL_PERF_CNT_EN is defined.
interface ctrl_mc_if #(
    parameter int INSTR_W = 9,
    parameter int ACC_W   = 8,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] Instruction;
    logic [ACC_W-1:0]   AccInput;
    logic PC_Jmp_Flag, PC_Beq_Flag;
    logic LUT_Write_En, LUT_Read_En, LUT_Load_Hi;
    logic Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc;
    logic Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm, Acc_Load_Hi;
    logic Mem_Write_En;
    logic [4:0] ALU_Opcode;
    logic Stall, Ack;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] Retire_Cnt, Stall_Cnt;
`endif

    modport master (
        output Instruction, AccInput,
        input  PC_Jmp_Flag, PC_Beq_Flag, LUT_Write_En, LUT_Read_En, LUT_Load_Hi,
        input  Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc,
        input  Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm, Acc_Load_Hi,
        input  Mem_Write_En, ALU_Opcode, Stall, Ack
`ifdef CTRL_PERF_CNT_EN
        , input Retire_Cnt, Stall_Cnt
`endif
    );

    modport slave (
        input  Instruction, AccInput,
        output PC_Jmp_Flag, PC_Beq_Flag, LUT_Write_En, LUT_Read_En, LUT_Load_Hi,
        output Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc,
        output Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm, Acc_Load_Hi,
        output Mem_Write_En, ALU_Opcode, Stall, Ack
`ifdef CTRL_PERF_CNT_EN
        , output Retire_Cnt, Stall_Cnt
`endif
    );
endinterface

// File: rtl/ctrl_decode.sv
// Pure opcode-to-control-word map, including the branch condition test.
// Zero latency, no state, no backpressure.
module ctrl_decode
    import ctrl_mc_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int BR_MODE = BR_EQ_ONE
) (
    input  logic [4:0]       opcode_i,
    input  logic [ACC_W-1:0] acc_i,
    output ctrl_word_t       cw_o,
    output logic             mem_o,
    output logic             halt_o
);
    logic br_taken;

    assign br_taken = (BR_MODE == BR_NONZERO) ? (acc_i != '0) : (acc_i == ACC_W'(1));

    always_comb begin
        cw_o   = '0;
        mem_o  = 1'b0;
        halt_o = 1'b0;
        case (opcode_i)
            OP_AND, OP_ORR, OP_XOR_B, OP_XOR_G, OP_ADD, OP_SHL, OP_SHR: begin
                cw_o.reg_write_en = 1'b1;
                cw_o.reg_from_alu = 1'b1;
                case (opcode_i)
                    OP_AND:   cw_o.alu_opcode = ALU_AND;
                    OP_ORR:   cw_o.alu_opcode = ALU_ORR;
                    OP_XOR_B: cw_o.alu_opcode = ALU_XOR_B;
                    OP_XOR_G: cw_o.alu_opcode = ALU_XOR_G;
                    OP_ADD:   cw_o.alu_opcode = ALU_ADD;
                    OP_SHL:   cw_o.alu_opcode = ALU_SHL;
                    default:  cw_o.alu_opcode = ALU_SHR;
                endcase
            end
            OP_CMP, OP_CMP_LS: begin
                cw_o.acc_write_en = 1'b1;
                cw_o.acc_from_alu = 1'b1;
                cw_o.alu_opcode   = (opcode_i == OP_CMP) ? ALU_CMP : ALU_CMP_LS;
            end
            OP_STA: begin
                cw_o.reg_write_en = 1'b1;
                cw_o.reg_from_acc = 1'b1;
            end
            OP_LDA: begin
                cw_o.acc_write_en = 1'b1;
                cw_o.acc_from_reg = 1'b1;
            end
            OP_SET_H, OP_SET_L: begin
                cw_o.acc_write_en = 1'b1;
                cw_o.acc_from_imm = 1'b1;
                cw_o.acc_load_hi  = (opcode_i == OP_SET_H);
            end
            OP_JMP: begin
                cw_o.lut_read_en = 1'b1;
                cw_o.pc_jmp_flag = 1'b1;
            end
            OP_BEQ: begin
                cw_o.lut_read_en = 1'b1;
                cw_o.pc_beq_flag = br_taken;
            end
            OP_LD_LUT_H, OP_LD_LUT_L: begin
                cw_o.lut_write_en = 1'b1;
                cw_o.lut_load_hi  = (opcode_i == OP_LD_LUT_H);
            end
            OP_LDR: begin
                cw_o.reg_write_en = 1'b1;
                cw_o.reg_from_mem = 1'b1;
                mem_o             = 1'b1;
            end
            OP_STR: begin
                cw_o.mem_write_en = 1'b1;
                mem_o             = 1'b1;
            end
            OP_HLT:  halt_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle control decoder: stalls the PC across slow data-memory accesses and halts stickily.
// Outputs are combinational from state and Instruction; optional CTRL_PERF_CNT_EN adds perf counters.
module ctrl_mc
    import ctrl_mc_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int OP_W    = 5,
    parameter int ACC_W   = 8,
    parameter int MEM_LAT = 1,
    parameter int BR_MODE = BR_EQ_ONE,
    parameter int CNT_W   = 16
) (
    input  logic     Clk,
    input  logic     Reset,
    ctrl_mc_if.slave bus
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    ctrl_state_t state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    ctrl_word_t  cw, out;
    logic        dec_mem, dec_halt, halt_req, stall, ack;

    ctrl_decode #(.ACC_W(ACC_W), .BR_MODE(BR_MODE)) u_decode (
        .opcode_i (5'(bus.Instruction[INSTR_W-1 -: OP_W])),
        .acc_i    (bus.AccInput),
        .cw_o     (cw),
        .mem_o    (dec_mem),
        .halt_o   (dec_halt)
    );

    assign halt_req = dec_halt || (&bus.Instruction);

    always_comb begin
        out        = '0;
        stall      = 1'b0;
        ack        = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    ack     = 1'b1;
                    stall   = 1'b1;
                    state_d = HALT;
                end else begin
                    out = cw;
                    if (dec_mem && (MEM_LAT > 1)) begin
                        stall            = 1'b1;
                        out.reg_write_en = 1'b0;
                        wait_cnt_d       = LAT_M1;
                        state_d          = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // Held instruction is re-decoded; only the last access cycle commits a load.
                out        = cw;
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q > 4'd1) begin
                    stall            = 1'b1;
                    out.reg_write_en = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                ack   = 1'b1;
                stall = 1'b1;
            end
            default: state_d = RUN;
        endcase
        if (Reset) begin
            out        = '0;
            stall      = 1'b0;
            ack        = 1'b0;
            state_d    = RUN;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.PC_Jmp_Flag  = out.pc_jmp_flag;
    assign bus.PC_Beq_Flag  = out.pc_beq_flag;
    assign bus.LUT_Write_En = out.lut_write_en;
    assign bus.LUT_Read_En  = out.lut_read_en;
    assign bus.LUT_Load_Hi  = out.lut_load_hi;
    assign bus.Reg_Write_En = out.reg_write_en;
    assign bus.Reg_From_ALU = out.reg_from_alu;
    assign bus.Reg_From_Mem = out.reg_from_mem;
    assign bus.Reg_From_Acc = out.reg_from_acc;
    assign bus.Acc_Write_En = out.acc_write_en;
    assign bus.Acc_From_Reg = out.acc_from_reg;
    assign bus.Acc_From_ALU = out.acc_from_alu;
    assign bus.Acc_From_Imm = out.acc_from_imm;
    assign bus.Acc_Load_Hi  = out.acc_load_hi;
    assign bus.Mem_Write_En = out.mem_write_en;
    assign bus.ALU_Opcode   = out.alu_opcode;
    assign bus.Stall        = stall;
    assign bus.Ack          = ack;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, stall_cnt_q;
    logic             retire_ev, stall_ev;

    // Halt entry is the only cycle that both stalls and retires.
    assign retire_ev = !Reset && (state_q != HALT) && (!stall || ack);
    assign stall_ev  = !Reset && (state_q != HALT) && stall && !ack;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (retire_ev && !(&retire_cnt_q)) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            if (stall_ev && !(&stall_cnt_q))   stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.Retire_Cnt = retire_cnt_q;
    assign bus.Stall_Cnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_mc.sv
// Drives a 3-cycle-memory / BEQ==1 instance and a single-cycle / BEQ!=0 instance with the same stream.
module tb_ctrl_mc;
    import ctrl_mc_pkg::*;

    localparam int J = 14, B = 13, LW = 12, LR = 11, LH = 10, RW = 9, RA = 8, RM = 7;
    localparam int RC = 6, AW = 5, AR = 4, AA = 3, AI = 2, AH = 1, MW = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_halted[2];
    int   m_busy[2];
    int   m_retire[2];
    int   m_stall[2];

    always #5 clk = ~clk;

    ctrl_mc_if #(.INSTR_W(9), .ACC_W(8), .CNT_W(16)) if_a ();
    ctrl_mc_if #(.INSTR_W(9), .ACC_W(8), .CNT_W(16)) if_b ();

    ctrl_mc #(.INSTR_W(9), .OP_W(5), .ACC_W(8), .MEM_LAT(3), .BR_MODE(0), .CNT_W(16)) dut_a (
        .Clk(clk), .Reset(rst), .bus(if_a.slave));
    ctrl_mc #(.INSTR_W(9), .OP_W(5), .ACC_W(8), .MEM_LAT(1), .BR_MODE(1), .CNT_W(16)) dut_b (
        .Clk(clk), .Reset(rst), .bus(if_b.slave));

    wire [21:0] obs_a = {if_a.PC_Jmp_Flag, if_a.PC_Beq_Flag, if_a.LUT_Write_En, if_a.LUT_Read_En,
        if_a.LUT_Load_Hi, if_a.Reg_Write_En, if_a.Reg_From_ALU, if_a.Reg_From_Mem, if_a.Reg_From_Acc,
        if_a.Acc_Write_En, if_a.Acc_From_Reg, if_a.Acc_From_ALU, if_a.Acc_From_Imm, if_a.Acc_Load_Hi,
        if_a.Mem_Write_En, if_a.ALU_Opcode, if_a.Stall, if_a.Ack};
    wire [21:0] obs_b = {if_b.PC_Jmp_Flag, if_b.PC_Beq_Flag, if_b.LUT_Write_En, if_b.LUT_Read_En,
        if_b.LUT_Load_Hi, if_b.Reg_Write_En, if_b.Reg_From_ALU, if_b.Reg_From_Mem, if_b.Reg_From_Acc,
        if_b.Acc_Write_En, if_b.Acc_From_Reg, if_b.Acc_From_ALU, if_b.Acc_From_Imm, if_b.Acc_Load_Hi,
        if_b.Mem_Write_En, if_b.ALU_Opcode, if_b.Stall, if_b.Ack};

    // Expected {flags, ALU_Opcode, Stall, Ack} from the instruction-level rules.
    function automatic logic [21:0] model_out(input int d, input logic r, input logic [8:0] ins,
                                              input logic [7:0] acc);
        logic [14:0] f;
        logic [4:0]  alu;
        logic [4:0]  op;
        logic        st;
        logic        fin;
        int          lat;
        lat = (d == 0) ? 3 : 1;
        f   = '0;
        alu = '0;
        st  = 1'b0;
        op  = ins[8:4];
        if (r) return '0;
        if (m_halted[d] != 0) return 22'b11;
        if (ins == 9'h1FF || op == OP_HLT) return 22'b11;
        fin = (m_busy[d] + 1 >= lat);
        case (op)
            OP_AND:    begin f[RW] = 1; f[RA] = 1; alu = 5'b00000; end
            OP_ORR:    begin f[RW] = 1; f[RA] = 1; alu = 5'b00001; end
            OP_XOR_B:  begin f[RW] = 1; f[RA] = 1; alu = 5'b00010; end
            OP_XOR_G:  begin f[RW] = 1; f[RA] = 1; alu = 5'b00011; end
            OP_ADD:    begin f[RW] = 1; f[RA] = 1; alu = 5'b00100; end
            OP_SHL:    begin f[RW] = 1; f[RA] = 1; alu = 5'b01100; end
            OP_SHR:    begin f[RW] = 1; f[RA] = 1; alu = 5'b01101; end
            OP_CMP:    begin f[AW] = 1; f[AA] = 1; alu = 5'b00111; end
            OP_CMP_LS: begin f[AW] = 1; f[AA] = 1; alu = 5'b01011; end
            OP_STA:    begin f[RW] = 1; f[RC] = 1; end
            OP_LDA:    begin f[AW] = 1; f[AR] = 1; end
            OP_SET_H:  begin f[AW] = 1; f[AI] = 1; f[AH] = 1; end
            OP_SET_L:  begin f[AW] = 1; f[AI] = 1; end
            OP_JMP:    begin f[LR] = 1; f[J] = 1; end
            OP_BEQ:    begin f[LR] = 1; f[B] = (d == 0) ? (acc == 8'd1) : (acc != 8'd0); end
            OP_LD_LUT_H: begin f[LW] = 1; f[LH] = 1; end
            OP_LD_LUT_L: f[LW] = 1;
            OP_LDR:    begin f[RM] = 1; f[RW] = fin; st = !fin; end
            OP_STR:    begin f[MW] = 1; st = !fin; end
            default: ;
        endcase
        return {f, alu, st, 1'b0};
    endfunction

    task automatic model_step(input int d, input logic r, input logic [21:0] e);
        if (r) begin
            m_halted[d] = 0; m_busy[d] = 0; m_retire[d] = 0; m_stall[d] = 0;
        end else if (m_halted[d] == 0) begin
            if (e[0]) begin m_halted[d] = 1; m_retire[d]++; end
            else if (e[1]) begin m_busy[d]++; m_stall[d]++; end
            else begin m_busy[d] = 0; m_retire[d]++; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cyc(input logic r, input logic [8:0] ins, input logic [7:0] acc);
        logic [21:0] ea, eb;
        rst = r;
        if_a.Instruction = ins; if_b.Instruction = ins;
        if_a.AccInput = acc;    if_b.AccInput = acc;
        #3;
        ea = model_out(0, r, ins, acc);
        eb = model_out(1, r, ins, acc);
        check("outs_a", 32'(obs_a), 32'(ea));
        check("outs_b", 32'(obs_b), 32'(eb));
`ifdef CTRL_PERF_CNT_EN
        check("retire_a", 32'(if_a.Retire_Cnt), 32'(m_retire[0]));
        check("stallc_a", 32'(if_a.Stall_Cnt), 32'(m_stall[0]));
        check("retire_b", 32'(if_b.Retire_Cnt), 32'(m_retire[1]));
        check("stallc_b", 32'(if_b.Stall_Cnt), 32'(m_stall[1]));
`endif
        model_step(0, r, ea);
        model_step(1, r, eb);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mk(input opcode_e op);
        return {op, 4'h5};
    endfunction

    initial begin
        logic [8:0] ins;
        logic [4:0] op;
        logic [7:0] acc;
        logic       r;
        int         sel;
        for (int d = 0; d < 2; d++) begin
            m_halted[d] = 0; m_busy[d] = 0; m_retire[d] = 0; m_stall[d] = 0;
        end
        // reset with LDR present, then ADD
        cyc(1, mk(OP_LDR), 8'h00);
        cyc(1, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_ADD), 8'h00);
        check("add_stall", 32'(if_a.Stall), 32'd0);
        // held LDR over three access cycles
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_ADD), 8'h00);
        // STR aborted by reset
        cyc(0, mk(OP_STR), 8'h00);
        cyc(1, mk(OP_STR), 8'h00);
        cyc(0, mk(OP_ADD), 8'h00);
        // branch conditions
        cyc(0, mk(OP_BEQ), 8'h01);
        cyc(0, mk(OP_BEQ), 8'h02);
        cyc(0, mk(OP_BEQ), 8'h00);
        cyc(0, mk(OP_BEQ), 8'hFF);
        // halt is sticky until reset, via HLT and via all-ones
        cyc(0, mk(OP_HLT), 8'h00);
        cyc(0, mk(OP_ADD), 8'h00);
        cyc(0, mk(OP_STR), 8'h00);
        cyc(1, mk(OP_ADD), 8'h00);
        cyc(0, mk(OP_ADD), 8'h00);
        cyc(0, 9'h1FF, 8'h00);
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(1, mk(OP_ADD), 8'h00);
        // ADD, LDR, ADD from a clean reset
        cyc(0, mk(OP_ADD), 8'h00);
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_LDR), 8'h00);
        cyc(0, mk(OP_ADD), 8'h00);
`ifdef CTRL_PERF_CNT_EN
        check("perf_retire", 32'(if_a.Retire_Cnt), 32'd3);
        check("perf_stall", 32'(if_a.Stall_Cnt), 32'd2);
`endif
        // random stream; instruction is held while the slow instance is mid-access
        ins = mk(OP_ADD);
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (m_busy[0] == 0) begin
                op = 5'($urandom_range(0, 31));
                if (op == OP_HLT && $urandom_range(0, 3) != 0) op = OP_LDR;
                ins = {op, 4'($urandom_range(0, 15))};
                if (sel == 1) ins = 9'h1FF;
            end
            case ($urandom_range(0, 3))
                0:       acc = 8'h00;
                1:       acc = 8'h01;
                2:       acc = 8'h02;
                default: acc = 8'($urandom_range(0, 255));
            endcase
            r = (sel >= 96) || (m_halted[0] != 0 && sel < 30);
            cyc(r, ins, acc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
